// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master: per-transfer CPOL/CPHA, bit order and length, full-duplex capture.
// Define SPI_MASTER_MC_LOOPBACK_EN to feed the RX shifter from the registered MOSI instead of MISO.
module spi_master_mc #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 32,
    parameter int NUM_CS  = 4,
    parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_start,
    input  logic              spi_cpol,
    input  logic              spi_cpha,
    input  logic              spi_dir,
    input  logic [CS_W-1:0]   spi_cs_sel,
    input  logic [7:0]        spi_data_depth,
    input  logic [DATA_W-1:0] spi_data_tx,
    output logic              spi_ready,
    output logic [DATA_W-1:0] spi_data_rx,
    output logic              spi_rx_valid,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_le
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0] DEPTH_MAX = 8'(DATA_W);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [8:0]        edge_q, edge_d;
    logic [7:0]        bit_q, bit_d;
    logic [7:0]        depth_q, depth_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rx_out_q, rx_out_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, dir_q, dir_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, valid_q, valid_d;
    logic [NUM_CS-1:0] le_q, le_d;

    logic       accept, div_done, leading, sample_now, last_edge, rx_in;
    logic [7:0] depth_clamp;

`ifdef SPI_MASTER_MC_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign rx_in       = mosi_q;
`else
    assign rx_in = spi_miso;
`endif

    // Bit n of the transfer order, counted from the first bit on the wire.
    function automatic logic tx_bit(input logic [DATA_W-1:0] data, input logic lsb_first,
                                    input logic [7:0] depth, input logic [7:0] n);
        logic [7:0]        pos;
        logic [DATA_W-1:0] sh;
        pos = lsb_first ? n : depth - 8'd1 - n;
        sh  = data >> pos;
        return sh[0];
    endfunction

    assign spi_ready   = (state_q == StIdle);
    assign accept      = spi_start && spi_ready && (spi_data_depth != 8'd0)
                         && (32'(spi_cs_sel) < NUM_CS);
    assign depth_clamp = (spi_data_depth > DEPTH_MAX) ? DEPTH_MAX : spi_data_depth;
    assign div_done    = (div_q == DIV_W'(CLK_DIV - 1));
    assign leading     = ~edge_q[0];
    assign sample_now  = leading ^ cpha_q;
    assign last_edge   = ((edge_q + 9'd1) == {depth_q, 1'b0});

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        edge_d   = edge_q;
        bit_d    = bit_q;
        depth_d  = depth_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rx_out_d = rx_out_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        dir_d    = dir_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        le_d     = le_q;
        valid_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                sclk_d = spi_cpol;
                if (accept) begin
                    state_d = StSetup;
                    div_d   = '0;
                    edge_d  = '0;
                    bit_d   = '0;
                    depth_d = depth_clamp;
                    tx_d    = spi_data_tx;
                    rx_d    = '0;
                    cpol_d  = spi_cpol;
                    cpha_d  = spi_cpha;
                    dir_d   = spi_dir;
                    mosi_d  = tx_bit(spi_data_tx, spi_dir, depth_clamp, 8'd0);
                    for (int i = 0; i < NUM_CS; i++) begin
                        le_d[i] = (spi_cs_sel != CS_W'(i));
                    end
                end
            end
            StSetup, StShift: begin
                div_d = div_q + DIV_W'(1);
                if (div_done) begin
                    div_d   = '0;
                    sclk_d  = ~sclk_q;
                    edge_d  = edge_q + 9'd1;
                    state_d = last_edge ? StHold : StShift;
                    if (sample_now) begin
                        rx_d = dir_q ? (rx_q | (DATA_W'(rx_in) << edge_q[8:1]))
                                     : {rx_q[DATA_W-2:0], rx_in};
                    end else if (!last_edge && (edge_q != 9'd0)) begin
                        // The first CPHA=1 leading edge keeps the bit already driven in setup.
                        bit_d  = bit_q + 8'd1;
                        mosi_d = tx_bit(tx_q, dir_q, depth_q, bit_q + 8'd1);
                    end
                end
            end
            StHold: begin
                div_d = div_q + DIV_W'(1);
                if (div_done) begin
                    div_d    = '0;
                    state_d  = StGap;
                    le_d     = '1;
                    rx_out_d = rx_q;
                    valid_d  = 1'b1;
                    mosi_d   = 1'b0;
                end
            end
            StGap: begin
                div_d = div_q + DIV_W'(1);
                if (div_done) begin
                    div_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            div_q    <= '0;
            edge_q   <= '0;
            bit_q    <= '0;
            depth_q  <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rx_out_q <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            dir_q    <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            le_q     <= '1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            bit_q    <= bit_d;
            depth_q  <= depth_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rx_out_q <= rx_out_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            dir_q    <= dir_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            le_q     <= le_d;
            valid_q  <= valid_d;
        end
    end

    assign spi_data_rx  = rx_out_q;
    assign spi_rx_valid = valid_q;
    assign spi_sclk     = sclk_q;
    assign spi_mosi     = mosi_q;
    assign spi_le       = le_q;

endmodule
